tdc_serial_cfg_shifter: RTL and testbench

Downstream stage of the I2C register bank. Takes the 13 configuration bytes: byte 1 holds the start bit, bytes 2..13 form a 96-bit configuration word. On each rising edge of the start bit it pulses the TDC chip reset, shifts the latched word out MSB-first on a prescaled serial clock, then pulses the capture strobe. Pins are active-high here; the top level inverts them for the pads.

---
 rtl/tdc_serial_cfg_shifter_pkg.sv | 22 ++
 rtl/tdc_serial_cfg_shifter_prescaler.sv | 36 +++
 rtl/tdc_serial_cfg_shifter.sv | 184 ++++++++++++++++++
 tb/tb_tdc_serial_cfg_shifter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_serial_cfg_shifter_pkg.sv
// Shared types and defaults for the TDC serial configuration shifter.
package tdc_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESET   = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int CFG_NBYTES       = 12;
    localparam int CFG_WORD_W       = 8 * CFG_NBYTES;
    localparam int DEF_CLK_DIV      = 8;
    localparam int DEF_RESET_CYCLES = 16;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdc_serial_cfg_shifter_prescaler.sv
// Serial-clock prescaler: tick in the last cycle of every CLK_DIV-cycle window.
module cfg_prescaler
    import tdc_cfg_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic reload,
    output logic tick
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (reload || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tdc_serial_cfg_shifter.sv
// Shifts the latched configuration word to the TDC chip: reset pulse, serial shift, capture strobe.
// Optional READBACK_EN adds p_sdo sampling into rb_data and an rb_mismatch flag.
module tdc_serial_cfg_shifter
    import tdc_cfg_pkg::*;
#(
    parameter int NBYTES       = CFG_NBYTES,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    input  logic [7:0]            start_reg,
    input  logic [8*NBYTES-1:0]   cfg_data,
`ifdef READBACK_EN
    input  logic                  p_sdo,
    output logic [8*NBYTES-1:0]   rb_data,
    output logic                  rb_mismatch,
`endif
    output logic                  p_sck,
    output logic                  p_sda,
    output logic                  p_scapt,
    output logic                  p_reset,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 8 * NBYTES;
    localparam int BW = cnt_width(W);
    localparam int RW = cnt_width(RESET_CYCLES);

    state_t          state_q, state_d;
    logic            start_q;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic            phase_q, phase_d;
    logic            p_sck_q, p_sda_q, p_scapt_q, p_reset_q, busy_q, done_q;
    logic            p_sck_d, p_sda_d, p_scapt_d, p_reset_d, busy_d, done_d;
    logic            trigger;
    logic            tick;
    logic            start_unused;

    assign start_unused = ^start_reg[7:1];

    // Reloading on every state change aligns the first half-period to the state entry.
    cfg_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clkin  (clkin),
        .rst_n  (rst_n),
        .reload (state_d != state_q),
        .tick   (tick)
    );

    assign trigger = start_reg[0] & ~start_q & (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        rcnt_d  = rcnt_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = RESET;
                    shreg_d = cfg_data;
                    bit_d   = '0;
                    rcnt_d  = '0;
                    phase_d = 1'b0;
                end
            end
            RESET: begin
                if (rcnt_q == RW'(RESET_CYCLES - 1)) begin
                    state_d = SHIFT;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == BW'(W - 1)) begin
                            state_d = CAPTURE;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shreg_d = {shreg_q[W-2:0], 1'b0};
                        end
                    end
                end
            end
            CAPTURE: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pins are decoded from the next state so every output leaves a flop.
        p_reset_d = (state_d == RESET);
        p_sck_d   = (state_d == SHIFT) && phase_d;
        p_sda_d   = (state_d == SHIFT) && shreg_d[W-1];
        p_scapt_d = (state_d == CAPTURE);
        busy_d    = (state_d == RESET) || (state_d == SHIFT) || (state_d == CAPTURE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clkin) begin
        // start_q follows the level even in reset so a request held across release is not an edge.
        start_q <= start_reg[0];
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_q     <= '0;
            rcnt_q    <= '0;
            phase_q   <= 1'b0;
            p_sck_q   <= 1'b0;
            p_sda_q   <= 1'b0;
            p_scapt_q <= 1'b0;
            p_reset_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_q     <= bit_d;
            rcnt_q    <= rcnt_d;
            phase_q   <= phase_d;
            p_sck_q   <= p_sck_d;
            p_sda_q   <= p_sda_d;
            p_scapt_q <= p_scapt_d;
            p_reset_q <= p_reset_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign p_sck   = p_sck_q;
    assign p_sda   = p_sda_q;
    assign p_scapt = p_scapt_q;
    assign p_reset = p_reset_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef READBACK_EN
    logic [W-1:0] rb_q, rb_d;
    logic [W-1:0] word_q, word_d;
    logic         mis_q, mis_d;

    always_comb begin
        rb_d   = rb_q;
        word_d = word_q;
        mis_d  = mis_q;
        if (trigger) begin
            rb_d   = '0;
            word_d = cfg_data;
            mis_d  = 1'b0;
        end else if ((state_q == SHIFT) && tick && !phase_q) begin
            rb_d = {rb_q[W-2:0], p_sdo};
        end else if ((state_d == DONE) && (state_q != DONE)) begin
            mis_d = (rb_q != word_q);
        end
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            rb_q   <= '0;
            word_q <= '0;
            mis_q  <= 1'b0;
        end else begin
            rb_q   <= rb_d;
            word_q <= word_d;
            mis_q  <= mis_d;
        end
    end

    assign rb_data     = rb_q;
    assign rb_mismatch = mis_q;
`endif

endmodule

// File: tb/tb_tdc_serial_cfg_shifter.sv
// Self-checking bench for tdc_serial_cfg_shifter (CLK_DIV=2, RESET_CYCLES=4, NBYTES=12).
module tb_tdc_serial_cfg_shifter;

    localparam int NB    = 12;
    localparam int W     = 8 * NB;
    localparam int D     = 2;
    localparam int R     = 4;
    localparam int TOTAL = R + 2 * D * W + D + 1;   // cycle offset of the done pulse

    logic           clkin = 1'b0;
    logic           rst_n;
    logic [7:0]     start_reg;
    logic [W-1:0]   cfg_data;
    logic           p_sck, p_sda, p_scapt, p_reset, busy, done;
    logic [5:0]     pins;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clkin = ~clkin;

    assign pins = {p_reset, p_sck, p_sda, p_scapt, busy, done};

`ifdef READBACK_EN
    logic         p_sdo = 1'b0;
    logic [W-1:0] rb_data;
    logic         rb_mismatch;
    logic         sdo_zero = 1'b0;
    always @(posedge clkin) p_sdo <= sdo_zero ? 1'b0 : p_sda;
`endif

    tdc_serial_cfg_shifter #(.NBYTES(NB), .CLK_DIV(D), .RESET_CYCLES(R)) dut (
        .clkin       (clkin),
        .rst_n       (rst_n),
        .start_reg   (start_reg),
        .cfg_data    (cfg_data),
`ifdef READBACK_EN
        .p_sdo       (p_sdo),
        .rb_data     (rb_data),
        .rb_mismatch (rb_mismatch),
`endif
        .p_sck       (p_sck),
        .p_sda       (p_sda),
        .p_scapt     (p_scapt),
        .p_reset     (p_reset),
        .busy        (busy),
        .done        (done)
    );

    // Reference timeline: expected {p_reset,p_sck,p_sda,p_scapt,busy,done} t cycles after the trigger edge.
    function automatic logic [5:0] model(input int t, input logic [W-1:0] word);
        int s;
        int c;
        logic [5:0] e;
        e = '0;
        s = t - R - 1;
        c = s - 2 * D * W;
        if (t >= 1 && t <= R)
            e = 6'b100010;
        else if (s >= 0 && s < 2 * D * W)
            e = {1'b0, ((s % (2 * D)) >= D), word[W - 1 - s / (2 * D)], 1'b0, 1'b1, 1'b0};
        else if (c >= 0 && c < D)
            e = 6'b000110;
        else if (c == D)
            e = 6'b000001;
        return e;
    endfunction

    task automatic check6(input string nm, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: pins {rst,sck,sda,capt,busy,done} got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic check_w(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_i(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    logic [5:0] obs [0:TOTAL+3];

    task automatic run_transfer(input logic [W-1:0] word, input bit noise, input int abort_bit);
        logic [W-1:0] stream;
        int nrise;
        int nbusy;
        logic prev_sck;
        bit aborted;
        stream   = '0;
        nrise    = 0;
        nbusy    = 0;
        prev_sck = 1'b0;
        aborted  = 1'b0;
        start_reg = 8'($urandom) & 8'hFE;
        step();
        check6("pre_idle", pins, 6'b0);
        start_reg[0] = 1'b1;
        cfg_data     = word;
        for (int t = 1; t <= TOTAL + 3; t++) begin
            step();
            obs[t] = pins;
            check6($sformatf("cyc%0d", t), pins, model(t, word));
            if (p_sck && !prev_sck) begin
                stream = {stream[W-2:0], p_sda};
                nrise++;
            end
            prev_sck = p_sck;
            if (busy) nbusy++;
`ifdef READBACK_EN
            if (t == TOTAL) begin
                check_i("rb_mismatch", int'(rb_mismatch), sdo_zero ? int'(word != '0) : 0);
                if (!sdo_zero) check_w("rb_data", rb_data, word);
            end
`endif
            if (abort_bit >= 0 && t == R + 1 + abort_bit * 2 * D) begin
                rst_n     = 1'b0;
                start_reg = 8'h00;
                step();
                check6("abort", pins, 6'b0);
`ifdef READBACK_EN
                check_w("abort_rb", rb_data, '0);
`endif
                rst_n = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    step();
                    check6("post_abort", pins, 6'b0);
                end
                aborted = 1'b1;
                break;
            end
            // Inputs set here are sampled at the edge closing cycle t.
            if (noise && t < TOTAL - 1) begin
                cfg_data  = {$urandom, $urandom, $urandom};
                start_reg = 8'($urandom);
            end
            if (t == TOTAL - 1) start_reg = 8'h00;
            if (t == TOTAL)     start_reg = 8'h01;   // edge during DONE must be ignored
        end
        if (!aborted) begin
            check_w("stream", stream, word);
            check_i("sck_pulses", nrise, W);
            check_i("busy_cycles", nbusy, TOTAL - 1);
        end
        start_reg = 8'h00;
    endtask

    typedef struct {
        int         t;
        logic [5:0] exp;
        string      nm;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1,   6'b100010, "rst_first"};
        vecs[1]  = '{4,   6'b100010, "rst_last"};
        vecs[2]  = '{5,   6'b001010, "bit0_low"};
        vecs[3]  = '{7,   6'b011010, "bit0_high"};
        vecs[4]  = '{9,   6'b000010, "bit1_low"};
        vecs[5]  = '{11,  6'b010010, "bit1_high"};
        vecs[6]  = '{385, 6'b001010, "bit95_low"};
        vecs[7]  = '{387, 6'b011010, "bit95_high"};
        vecs[8]  = '{389, 6'b000110, "capt_first"};
        vecs[9]  = '{390, 6'b000110, "capt_last"};
        vecs[10] = '{391, 6'b000001, "done_pulse"};
        vecs[11] = '{392, 6'b000000, "back_idle"};

        rst_n     = 1'b0;
        start_reg = 8'($urandom);
        cfg_data  = {$urandom, $urandom, $urandom};
        step();
        check6("reset_out", pins, 6'b0);
        start_reg = 8'($urandom) | 8'h01;
        cfg_data  = {$urandom, $urandom, $urandom};
        step();
        check6("reset_out2", pins, 6'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check6("held_start", pins, 6'b0);
        end

        run_transfer({8'hA5, 80'h0, 8'h01}, 1'b0, -1);
        for (int i = 0; i < 12; i++) begin
            check6(vecs[i].nm, obs[vecs[i].t], vecs[i].exp);
        end

        for (int n = 0; n < 3; n++) begin
            run_transfer({$urandom, $urandom, $urandom}, 1'b1, -1);
        end

        run_transfer({$urandom, $urandom, $urandom}, 1'b1, 40);
        run_transfer({$urandom, $urandom, $urandom}, 1'b0, -1);

`ifdef READBACK_EN
        sdo_zero = 1'b1;
        run_transfer({$urandom, $urandom, $urandom} | 96'h1, 1'b0, -1);
        sdo_zero = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
